// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control pipeline registers with load-use stall, branch flush and
// operand forwarding selects. Define CTRL_PIPE_FORWARD_EN to enable forwarding; otherwise RAW hazards stall.
module ctrl_pipeline #(
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CTRL_EX = 3,
  parameter int NB_REG     = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  input  logic [NB_REG-1:0]     i_id_rs,
  input  logic [NB_REG-1:0]     i_id_rt,
  input  logic [NB_REG-1:0]     i_id_rd,
  input  logic                  i_branch_taken,
  output logic [NB_CTRL_EX-1:0] o_ex_ctrl,
  output logic [NB_CTRL_M-1:0]  o_mem_ctrl,
  output logic [NB_CTRL_WB-1:0] o_wb_ctrl,
  output logic [NB_REG-1:0]     o_wb_dest,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b
);

  localparam int WB_REGWRITE = 1;
  localparam int M_MEMREAD   = 1;
  localparam int EX_REGDST   = 2;

  typedef struct packed {
    logic [NB_CTRL_WB-1:0] wb;
    logic [NB_CTRL_M-1:0]  mem;
    logic [NB_CTRL_EX-1:0] exc;
    logic [NB_REG-1:0]     rs;
    logic [NB_REG-1:0]     rt;
    logic [NB_REG-1:0]     dest;
  } idex_t;

  typedef struct packed {
    logic [NB_CTRL_WB-1:0] wb;
    logic [NB_CTRL_M-1:0]  mem;
    logic [NB_REG-1:0]     dest;
  } exmem_t;

  typedef struct packed {
    logic [NB_CTRL_WB-1:0] wb;
    logic [NB_REG-1:0]     dest;
  } memwb_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   hazard;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic hit(input logic wr, input logic [NB_REG-1:0] dst,
                               input logic [NB_REG-1:0] src);
    return wr && (dst != '0) && (dst == src);
  endfunction

`ifdef CTRL_PIPE_FORWARD_EN
  always_comb begin
    hazard = idex_q.mem[M_MEMREAD] &&
             (hit(1'b1, idex_q.dest, i_id_rs) || hit(1'b1, idex_q.dest, i_id_rt));
    o_fwd_a = 2'b00;
    if (hit(exmem_q.wb[WB_REGWRITE], exmem_q.dest, idex_q.rs))      o_fwd_a = 2'b10;
    else if (hit(memwb_q.wb[WB_REGWRITE], memwb_q.dest, idex_q.rs)) o_fwd_a = 2'b01;
    o_fwd_b = 2'b00;
    if (hit(exmem_q.wb[WB_REGWRITE], exmem_q.dest, idex_q.rt))      o_fwd_b = 2'b10;
    else if (hit(memwb_q.wb[WB_REGWRITE], memwb_q.dest, idex_q.rt)) o_fwd_b = 2'b01;
  end
`else
  // Without bypass paths, ID waits until every in-flight writer has reached MEM/WB.
  logic unused_srcs;
  assign unused_srcs = ^{idex_q.rs, idex_q.rt};
  always_comb begin
    hazard = hit(idex_q.wb[WB_REGWRITE],  idex_q.dest,  i_id_rs) ||
             hit(idex_q.wb[WB_REGWRITE],  idex_q.dest,  i_id_rt) ||
             hit(exmem_q.wb[WB_REGWRITE], exmem_q.dest, i_id_rs) ||
             hit(exmem_q.wb[WB_REGWRITE], exmem_q.dest, i_id_rt);
    o_fwd_a = 2'b00;
    o_fwd_b = 2'b00;
  end
`endif

  // A taken branch squashes the stalled instruction, so the stall is moot.
  assign o_stall = hazard && !i_branch_taken;
  assign o_flush = i_branch_taken;

  always_comb begin
    idex_d = '0;
    if (!o_stall && !i_branch_taken) begin
      idex_d.wb   = i_ctrl_wb_bus;
      idex_d.mem  = i_ctrl_mem_bus;
      idex_d.exc  = i_ctrl_exc_bus;
      idex_d.rs   = i_id_rs;
      idex_d.rt   = i_id_rt;
      idex_d.dest = i_ctrl_exc_bus[EX_REGDST] ? i_id_rd : i_id_rt;
    end
    exmem_d = '0;
    if (!i_branch_taken) begin
      exmem_d.wb   = idex_q.wb;
      exmem_d.mem  = idex_q.mem;
      exmem_d.dest = idex_q.dest;
    end
    memwb_d.wb   = exmem_q.wb;
    memwb_d.dest = exmem_q.dest;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign o_ex_ctrl  = idex_q.exc;
  assign o_mem_ctrl = exmem_q.mem;
  assign o_wb_ctrl  = memwb_q.wb;
  assign o_wb_dest  = memwb_q.dest;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Table-driven directed sequences plus randomized instruction stream against a stage-slot reference model.
module tb_ctrl_pipeline;
  logic       clk = 1'b0;
  logic       i_rst, i_branch_taken;
  logic [1:0] i_ctrl_wb_bus;
  logic [2:0] i_ctrl_mem_bus, i_ctrl_exc_bus;
  logic [4:0] i_id_rs, i_id_rt, i_id_rd;
  logic [2:0] o_ex_ctrl, o_mem_ctrl;
  logic [1:0] o_wb_ctrl, o_fwd_a, o_fwd_b;
  logic [4:0] o_wb_dest;
  logic       o_stall, o_flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.NB_CTRL_WB(2), .NB_CTRL_M(3), .NB_CTRL_EX(3), .NB_REG(5)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_ctrl_wb_bus(i_ctrl_wb_bus), .i_ctrl_mem_bus(i_ctrl_mem_bus), .i_ctrl_exc_bus(i_ctrl_exc_bus),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_rd(i_id_rd), .i_branch_taken(i_branch_taken),
    .o_ex_ctrl(o_ex_ctrl), .o_mem_ctrl(o_mem_ctrl), .o_wb_ctrl(o_wb_ctrl), .o_wb_dest(o_wb_dest),
    .o_stall(o_stall), .o_flush(o_flush), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b));

  localparam int NOP = 0, ADD = 1, LW = 2, SW = 3, BEQ = 4, RND = 5;

  // {wb, mem, exc} per instruction class
  function automatic logic [7:0] enc(input int kind);
    case (kind)
      ADD:     return {2'b10, 3'b000, 3'b100};
      LW:      return {2'b11, 3'b010, 3'b001};
      SW:      return {2'b00, 3'b001, 3'b001};
      BEQ:     return {2'b00, 3'b100, 3'b010};
      RND:     return 8'($urandom);
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    logic        rst;
    int          kind;
    logic [4:0]  rs, rt, rd;
    logic        br;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic rst, input int kind, input logic [4:0] rs, rt, rd,
                               input logic br, input logic [2:0] ex, mem, input logic [1:0] wb,
                               input logic [4:0] dest, input logic stall, flush,
                               input logic [1:0] fa, fb);
    vec_t v;
    v.rst = rst; v.kind = kind; v.rs = rs; v.rt = rt; v.rd = rd; v.br = br;
    v.exp = {ex, mem, wb, dest, stall, flush, fa, fb};
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [7:0] bus, input logic [4:0] rs, rt, rd,
                       input logic br);
    i_rst = rst;
    {i_ctrl_wb_bus, i_ctrl_mem_bus, i_ctrl_exc_bus} = bus;
    i_id_rs = rs; i_id_rt = rt; i_id_rd = rd; i_branch_taken = br;
  endtask

  function automatic logic [18:0] actual();
    return {o_ex_ctrl, o_mem_ctrl, o_wb_ctrl, o_wb_dest, o_stall, o_flush, o_fwd_a, o_fwd_b};
  endfunction

  task automatic check(input string name, input int idx, input logic [18:0] exp);
    tests++;
    if (actual() !== exp) begin
      fails++;
      $display("FAIL %s %0d: got ex=%b mem=%b wb=%b dest=%0d stall=%b flush=%b fa=%b fb=%b, want ex=%b mem=%b wb=%b dest=%0d stall=%b flush=%b fa=%b fb=%b",
               name, idx, o_ex_ctrl, o_mem_ctrl, o_wb_ctrl, o_wb_dest, o_stall, o_flush, o_fwd_a, o_fwd_b,
               exp[18:16], exp[15:13], exp[12:11], exp[10:6], exp[5], exp[4], exp[3:2], exp[1:0]);
    end
  endtask

  // Reference model: one record per occupied stage slot (0 = EX, 1 = MEM, 2 = WB).
  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [2:0] exc;
    logic [4:0] rs, rt, dest;
  } ins_t;

  ins_t st[3];

  function automatic logic writes(input ins_t s, input logic [4:0] r);
    return s.wb[1] && s.dest != 5'd0 && s.dest == r;
  endfunction

  function automatic logic [1:0] src_sel(input logic [4:0] r);
`ifdef CTRL_PIPE_FORWARD_EN
    if (writes(st[1], r)) return 2'b10;
    if (writes(st[2], r)) return 2'b01;
`endif
    return 2'b00 & {2{r[0]}};
  endfunction

  function automatic logic model_hazard(input logic [4:0] rs, rt);
    logic h = 1'b0;
`ifdef CTRL_PIPE_FORWARD_EN
    h = st[0].mem[1] && st[0].dest != 5'd0 && (st[0].dest == rs || st[0].dest == rt);
`else
    for (int k = 0; k < 2; k++) h |= writes(st[k], rs) || writes(st[k], rt);
`endif
    return h;
  endfunction

  initial begin
    logic [7:0] bus;
    logic [4:0] rs, rt, rd;
    logic       rst, br, stl, prev_stl;
    ins_t       nw, wbs;

`ifdef CTRL_PIPE_FORWARD_EN
    tbl.push_back(row(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, LW,  0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 8, 2, 6, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(row(1, ADD, 8, 2, 6, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 1, 1, 3, 0, 4, 0, 3, 8, 0, 0, 1, 0));
    tbl.push_back(row(1, ADD, 1, 1, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 3, 3, 5, 0, 4, 0, 2, 6, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 4, 0, 2, 3, 0, 0, 2, 2));
    tbl.push_back(row(1, ADD, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 0, 0, 1, 0, 4, 0, 2, 5, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, LW,  0, 9, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 9, 0, 2, 1, 1, 0, 2, 1, 0, 1, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
    tbl.push_back(row(0, ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0));
    tbl.push_back(row(1, LW,  9, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 0, 3, 5, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 4, 2, 6, 0, 4, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(row(1, ADD, 4, 2, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(row(1, ADD, 4, 2, 6, 0, 0, 0, 2, 4, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 0, 2, 6, 0, 0, 0, 0));
    tbl.push_back(row(1, LW,  0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 8, 2, 6, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, ADD, 0, 0, 7, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(1, NOP, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(row(0, ADD, 7, 7, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0));
    tbl.push_back(row(1, ADD, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, enc(tbl[i].kind), tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].br);
      #1;
      check("vec", i, tbl[i].exp);
    end

    // Randomized stream; the front end holds its instruction while stalled, as PC/IF-ID would.
    @(negedge clk);
    drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) st[k] = '0;
    prev_stl = 1'b0;
    bus = 8'h00; rs = 0; rt = 0; rd = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) != 0);
      br  = ($urandom_range(0, 9) == 0);
      if (!prev_stl) begin
        bus = enc($urandom_range(0, 5));
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      end
      drive(rst, bus, rs, rt, rd, br);
      #1;
      stl = model_hazard(rs, rt) && !br;
      check("rand", c, {st[0].exc, st[1].mem, st[2].wb, st[2].dest, stl, br,
                        src_sel(st[0].rs), src_sel(st[0].rt)});
      if (!rst) begin
        for (int k = 0; k < 3; k++) st[k] = '0;
        stl = 1'b0;
      end else begin
        wbs = '0; wbs.wb = st[1].wb; wbs.dest = st[1].dest;
        st[2] = wbs;
        st[1] = br ? '0 : st[0];
        nw = '0;
        nw.wb = bus[7:6]; nw.mem = bus[5:3]; nw.exc = bus[2:0];
        nw.rs = rs; nw.rt = rt; nw.dest = bus[2] ? rd : rt;
        st[0] = (br || stl) ? '0 : nw;
      end
      prev_stl = stl;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Carries the decoded control buses from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the MIPS core. It tracks each instruction's destination register and source registers alongside its control bits. It also raises the hazard controls the datapath consumes: load-use stall, branch flush and ALU operand forwarding selects. It sits between the opcode control decoder and the EX/MEM/WB datapath stages.

## Interface
- NB_CTRL_WB, 2, WB bus width: [1] RegWrite, [0] MemtoReg
- NB_CTRL_M, 3, MEM bus width: [2] Branch, [1] MemRead, [0] MemWrite
- NB_CTRL_EX, 3, EX bus width: [2] RegDst, [1] ALUOp, [0] ALUSrc
- NB_REG, 5, register-address width

- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_ctrl_wb_bus  in  NB_CTRL_WB  WB bus from decoder, ID stage
- i_ctrl_mem_bus  in  NB_CTRL_M  MEM bus from decoder, ID stage
- i_ctrl_exc_bus  in  NB_CTRL_EX  EX bus from decoder, ID stage
- i_id_rs, i_id_rt, i_id_rd  in  NB_REG each  register fields of the ID-stage instruction
- i_branch_taken  in  1  BEQ resolved taken in MEM stage
- o_ex_ctrl  out  NB_CTRL_EX  ID/EX EX bits
- o_mem_ctrl  out  NB_CTRL_M  EX/MEM MEM bits
- o_wb_ctrl  out  NB_CTRL_WB  MEM/WB WB bits
- o_wb_dest  out  NB_REG  MEM/WB destination register
- o_stall  out  1  hold PC and IF/ID
- o_flush  out  1  clear IF/ID
- o_fwd_a, o_fwd_b  out  2 each  ALU operand A/B select: 00 register file, 10 EX/MEM result, 01 MEM/WB result

## Operation
- ID/EX holds {wb, mem, exc, rs, rt, dest}. The destination is computed at capture: dest = RegDst ? i_id_rd : i_id_rt.
- EX/MEM holds {wb, mem, dest}. MEM/WB holds {wb, dest}.
- Load-use hazard: o_stall = idex MemRead & idex_dest != 0 & (idex_dest == i_id_rs | idex_dest == i_id_rt).
- Stall: ID/EX captures a bubble (all control, rs, rt and dest zero). EX/MEM and MEM/WB advance normally.
- Flush: i_branch_taken=1 sets o_flush=1 combinationally. On the next edge ID/EX and EX/MEM load bubbles. MEM/WB advances; the branch itself writes nothing.
- Flush has priority: o_stall is forced to 0 while i_branch_taken=1, because the stalled instruction is squashed.
- Forwarding for A, using idex_rs. B is identical using idex_rt.
  - Select 10 when exmem RegWrite, exmem_dest != 0 and exmem_dest == idex_rs.
  - Otherwise select 01 when memwb RegWrite, memwb_dest != 0 and memwb_dest == idex_rs.
  - Otherwise select 00.
  - EX/MEM wins over MEM/WB.
- Register 0 never causes a hazard or a forward.
- The register file is write-through. An instruction in MEM/WB is therefore never a hazard for ID.

## Timing
- Reset (i_rst=0 at an edge) zeroes all stage registers. All outputs are 0 the cycle after, including o_fwd_a/b=00.
- Reset overrides stall and flush, and takes effect mid-operation with no residual state.
- Latency: control presented in ID appears on o_ex_ctrl 1 cycle later, o_mem_ctrl after 2, o_wb_ctrl/o_wb_dest after 3.
- o_stall, o_flush, o_fwd_a, o_fwd_b are combinational from the current stage registers and ID inputs. They are valid in the same cycle.
- A stall lasts exactly one cycle per load-use pair. After the bubble, idex MemRead=0, so the hazard clears.
- Back-to-back loads feeding each other stall once per pair.

## Configuration
- CTRL_PIPE_FORWARD_EN defined: forwarding logic as above; stall only on load-use.
- Not defined:
  - o_fwd_a/b are tied to 00.
  - o_stall asserts when idex or exmem has RegWrite=1 with dest != 0 matching i_id_rs or i_id_rt.
  - It repeats each cycle until the writer reaches MEM/WB.
  - Flush priority is unchanged.

## Test plan
- Reset: drive R-type buses, hold i_rst=0 for 2 edges -> all outputs 0; release -> o_ex_ctrl=3'b100 one cycle after first capture.
- Pipeline latency: LW (wb 11, mem 010, exc 001, rt=5), then NOPs -> o_mem_ctrl=010 at +2, o_wb_ctrl=11 with o_wb_dest=5 at +3.
- Load-use: LW rt=8, then ADD rs=8 -> o_stall=1 for exactly one cycle, o_ex_ctrl=000 next cycle. With forwarding: o_fwd_a=01 when the ADD reaches EX.
- Forward priority: ADD rd=3, ADD rd=3, then SUB rs=3 rt=3 -> o_fwd_a=o_fwd_b=10. Register 0 destination -> 00.
- Flush over stall: i_branch_taken=1 in the same cycle as a load-use condition -> o_flush=1, o_stall=0; next cycle o_ex_ctrl=0 and o_mem_ctrl=0.
- Forwarding disabled build: ADD rd=4, then ADD rs=4 -> o_stall=1 for 2 consecutive cycles, o_fwd_a=00 throughout.
